// File: rtl/and_2.sv
// Bitwise AND with a registered copy, per-bit rising-edge pulse and a
// saturating count of cycles in which the registered result is all ones.
module and_2 #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 clr,
    output logic [WIDTH-1:0]     z,
    output logic [WIDTH-1:0]     z_q,
    output logic [WIDTH-1:0]     z_rise,
    output logic [CNT_WIDTH-1:0] hi_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] z_q_prev;

    assign z = x & y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q      <= '0;
            z_q_prev <= '0;
            z_rise   <= '0;
            hi_cnt   <= '0;
        end else begin
            z_q      <= z;
            z_q_prev <= z_q;
            z_rise   <= z_q & ~z_q_prev;
            // clear wins over increment; counter holds at all-ones
            if (clr)
                hi_cnt <= '0;
            else if ((&z_q) && (hi_cnt != CNT_MAX))
                hi_cnt <= hi_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_and_2.sv
// Bench for and_2: three instances (1-bit/16-bit count, 1-bit/4-bit count,
// 4-bit/16-bit count) checked against a reference model through scoreboards.
module tb_and_2;

    typedef struct {
        logic [3:0]  zq;
        logic [3:0]  rise;
        logic [15:0] cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        x_m = 1'b0, y_m = 1'b0, clr_m = 1'b0;
    logic        z_m, zq_m, rise_m;
    logic [15:0] cnt_m;
    logic        x_s = 1'b0, y_s = 1'b0, clr_s = 1'b0;
    logic        z_s, zq_s, rise_s;
    logic [3:0]  cnt_s;
    logic [3:0]  x_w = 4'h0, y_w = 4'h0;
    logic        clr_w = 1'b0;
    logic [3:0]  z_w, zq_w, rise_w;
    logic [15:0] cnt_w;

    int n_cmp = 0;
    int n_bad = 0;

    and_2 #(.WIDTH(1), .CNT_WIDTH(16)) u_main (
        .clk(clk), .rst_n(rst_n), .x(x_m), .y(y_m), .clr(clr_m),
        .z(z_m), .z_q(zq_m), .z_rise(rise_m), .hi_cnt(cnt_m));
    and_2 #(.WIDTH(1), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .x(x_s), .y(y_s), .clr(clr_s),
        .z(z_s), .z_q(zq_s), .z_rise(rise_s), .hi_cnt(cnt_s));
    and_2 #(.WIDTH(4), .CNT_WIDTH(16)) u_wide (
        .clk(clk), .rst_n(rst_n), .x(x_w), .y(y_w), .clr(clr_w),
        .z(z_w), .z_q(zq_w), .z_rise(rise_w), .hi_cnt(cnt_w));

    // Reference model: expectations are pushed at the edge that samples the inputs.
    logic        m_zq = 1'b0, m_prev = 1'b0, s_zq = 1'b0, s_prev = 1'b0;
    logic [3:0]  w_zq = 4'h0, w_prev = 4'h0;
    logic [15:0] m_cnt = 16'd0, s_cnt = 16'd0, w_cnt = 16'd0;
    exp_t q_m[$], q_s[$], q_w[$];

    function automatic logic [15:0] next_cnt(input logic c, input logic all1,
                                             input logic [15:0] cur, input logic [15:0] mx);
        if (c) return 16'd0;
        if (all1 && cur < mx) return cur + 16'd1;
        return cur;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_zq <= 1'b0; m_prev <= 1'b0; m_cnt <= 16'd0;
            s_zq <= 1'b0; s_prev <= 1'b0; s_cnt <= 16'd0;
            w_zq <= 4'h0; w_prev <= 4'h0; w_cnt <= 16'd0;
            q_m.delete(); q_s.delete(); q_w.delete();
        end else begin
            q_m.push_back('{zq: 4'(x_m & y_m), rise: 4'(m_zq & ~m_prev),
                            cnt: next_cnt(clr_m, m_zq, m_cnt, 16'hFFFF)});
            q_s.push_back('{zq: 4'(x_s & y_s), rise: 4'(s_zq & ~s_prev),
                            cnt: next_cnt(clr_s, s_zq, s_cnt, 16'd15)});
            q_w.push_back('{zq: x_w & y_w, rise: w_zq & ~w_prev,
                            cnt: next_cnt(clr_w, w_zq == 4'hF, w_cnt, 16'hFFFF)});
            m_zq <= x_m & y_m; m_prev <= m_zq; m_cnt <= next_cnt(clr_m, m_zq, m_cnt, 16'hFFFF);
            s_zq <= x_s & y_s; s_prev <= s_zq; s_cnt <= next_cnt(clr_s, s_zq, s_cnt, 16'd15);
            w_zq <= x_w & y_w; w_prev <= w_zq;
            w_cnt <= next_cnt(clr_w, w_zq == 4'hF, w_cnt, 16'hFFFF);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({zq_m, rise_m, cnt_m, zq_s, cnt_s, zq_w, rise_w, cnt_w} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got zq=%b rise=%b cnt=%0d cnt_s=%0d zq_w=%b cnt_w=%0d, want all 0",
                     zq_m, rise_m, cnt_m, cnt_s, zq_w, cnt_w);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] pats [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic       want [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            x_m = pats[i][1];
            y_m = pats[i][0];
            #10;
            n_cmp++;
            if (z_m !== want[i]) begin
                n_bad++;
                $display("FAIL truth_table x=%b y=%b: got z=%b want %b", x_m, y_m, z_m, want[i]);
            end
        end
    endtask

    task automatic test_count();
        exp_t e;
        x_m = 1'b1; y_m = 1'b1; clr_m = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (q_m.size() == 0) begin
                n_bad++;
                $display("FAIL count_queue cycle %0d: no expectation queued", i);
            end else begin
                e = q_m.pop_front();
                if ({zq_m, rise_m, cnt_m} !== {e.zq[0], e.rise[0], e.cnt}) begin
                    n_bad++;
                    $display("FAIL count cycle %0d: got zq=%b rise=%b cnt=%0d want zq=%b rise=%b cnt=%0d",
                             i, zq_m, rise_m, cnt_m, e.zq[0], e.rise[0], e.cnt);
                end
            end
            // absolute sequence independent of the model: rise only on cycle 1, count = cycle index
            n_cmp++;
            if ({zq_m, rise_m, cnt_m} !== {1'b1, (i == 1), 16'(i)}) begin
                n_bad++;
                $display("FAIL count_abs cycle %0d: got zq=%b rise=%b cnt=%0d want zq=1 rise=%0d cnt=%0d",
                         i, zq_m, rise_m, cnt_m, (i == 1), i);
            end
        end
    endtask

    task automatic test_toggle_clr();
        logic ys  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic prev = 1'b1;
        int   want_rises = 0;
        int   got_rises = 0;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            if (ys[i] && !prev) want_rises++;
            prev = ys[i];
        end
        x_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            y_m   = ys[i];
            clr_m = (i == 4);
            tick();
            got_rises += int'(rise_m);
            n_cmp++;
            if (q_m.size() == 0) begin
                n_bad++;
                $display("FAIL toggle_queue step %0d: no expectation queued", i);
            end else begin
                e = q_m.pop_front();
                if ({zq_m, rise_m, cnt_m} !== {e.zq[0], e.rise[0], e.cnt}) begin
                    n_bad++;
                    $display("FAIL toggle step %0d: got zq=%b rise=%b cnt=%0d want zq=%b rise=%b cnt=%0d",
                             i, zq_m, rise_m, cnt_m, e.zq[0], e.rise[0], e.cnt);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if (cnt_m !== 16'd0) begin
                    n_bad++;
                    $display("FAIL clr_priority: got cnt=%0d want 0", cnt_m);
                end
            end
        end
        clr_m = 1'b0;
        n_cmp++;
        if (got_rises != want_rises) begin
            n_bad++;
            $display("FAIL rise_pulses: got %0d want %0d", got_rises, want_rises);
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        q_s.delete();
        x_s = 1'b1; y_s = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (q_s.size() == 0) begin
                n_bad++;
                $display("FAIL sat_queue cycle %0d: no expectation queued", i);
            end else begin
                e = q_s.pop_front();
                if ({zq_s, rise_s, cnt_s} !== {e.zq[0], e.rise[0], e.cnt[3:0]}) begin
                    n_bad++;
                    $display("FAIL saturate cycle %0d: got zq=%b rise=%b cnt=%0d want zq=%b rise=%b cnt=%0d",
                             i, zq_s, rise_s, cnt_s, e.zq[0], e.rise[0], e.cnt[3:0]);
                end
            end
        end
        n_cmp++;
        if (cnt_s !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_hold: got cnt=%0d want 15", cnt_s);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        x_m = 1'b1; y_m = 1'b1;
        repeat (3) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({zq_m, rise_m, cnt_m, cnt_s, zq_s} !== '0 || z_m !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_async: got zq=%b rise=%b cnt=%0d cnt_s=%0d z=%b want 0 0 0 0 z=1",
                     zq_m, rise_m, cnt_m, cnt_s, z_m);
        end
        y_m = 1'b0;
        #1;
        n_cmp++;
        if (z_m !== 1'b0) begin
            n_bad++;
            $display("FAIL z_in_reset: got z=%b want 0", z_m);
        end
        y_m = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (q_m.size() == 0) begin
                n_bad++;
                $display("FAIL post_reset_queue cycle %0d: no expectation queued", i);
            end else begin
                e = q_m.pop_front();
                if ({zq_m, rise_m, cnt_m} !== {e.zq[0], e.rise[0], e.cnt}) begin
                    n_bad++;
                    $display("FAIL post_reset cycle %0d: got zq=%b rise=%b cnt=%0d want zq=%b rise=%b cnt=%0d",
                             i, zq_m, rise_m, cnt_m, e.zq[0], e.rise[0], e.cnt);
                end
            end
        end
    endtask

    task automatic test_wide();
        exp_t e;
        q_w.delete();
        x_w = 4'b1100; y_w = 4'b1010;
        #1;
        n_cmp++;
        if (z_w !== 4'b1000) begin
            n_bad++;
            $display("FAIL wide_z: got %b want 1000", z_w);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin x_w = 4'hF; y_w = 4'hF; end
            tick();
            n_cmp++;
            if (q_w.size() == 0) begin
                n_bad++;
                $display("FAIL wide_queue cycle %0d: no expectation queued", i);
            end else begin
                e = q_w.pop_front();
                if ({zq_w, rise_w, cnt_w} !== {e.zq, e.rise, e.cnt}) begin
                    n_bad++;
                    $display("FAIL wide cycle %0d: got zq=%b rise=%b cnt=%0d want zq=%b rise=%b cnt=%0d",
                             i, zq_w, rise_w, cnt_w, e.zq, e.rise, e.cnt);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if (cnt_w !== 16'd0) begin
                    n_bad++;
                    $display("FAIL wide_no_count: got cnt=%0d want 0", cnt_w);
                end
            end
        end
        n_cmp++;
        if (cnt_w !== 16'd2) begin
            n_bad++;
            $display("FAIL wide_all_ones_count: got cnt=%0d want 2", cnt_w);
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_count();
        test_toggle_clr();
        test_saturate();
        test_reset_mid();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
